score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_pkg.sv | 22 ++
 rtl/bcd_incrementer.sv | 40 ++++
 rtl/score_keeper.sv | 134 +++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_pkg
// Purpose  : Shared types and constants for the score keeper.
//            - state_e     : game FSM states (PLAY, OVER)
//            - bcd_digit_t : one packed BCD digit
//            - BCD_NINE    : largest BCD digit value
// Revision : 1.0 - initial release
// ============================================================================
package score_pkg;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'h9;

endpackage : score_pkg
`default_nettype wire

// File: rtl/bcd_incrementer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_incrementer
// Purpose  : Purely combinational +1 on a packed multi-digit BCD value.
// Ports    : value_i     - packed BCD input, digit 0 in bits [3:0]
//            sum_o       - value_i + 1 in BCD (wraps to zero when all nines)
//            all_nines_o - 1 when every digit of value_i is 9
// Revision : 1.0 - initial release
// ============================================================================
module bcd_incrementer
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 3
) (
  input  logic [NUM_DIGITS*4-1:0] value_i,
  output logic [NUM_DIGITS*4-1:0] sum_o,
  output logic                    all_nines_o
);

  // w_carry[g] is the carry into digit g; the +1 enters at digit 0.
  logic [NUM_DIGITS:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_t w_d;
    logic       w_is9;

    assign w_d   = value_i[g*4 +: 4];
    assign w_is9 = (w_d == BCD_NINE);

    assign sum_o[g*4 +: 4] = w_carry[g] ? (w_is9 ? 4'h0 : w_d + 4'h1) : w_d;
    assign w_carry[g+1]    = w_carry[g] & w_is9;
  end : g_digit

  // A carry out of the top digit happens exactly when every digit is nine.
  assign all_nines_o = w_carry[NUM_DIGITS];

endmodule : bcd_incrementer
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : BCD game score / high-score keeper with a PLAY/OVER FSM and a
//            registered display output.
// Ports    : clk        - system clock (rising edge)
//            rst_n      - asynchronous active-low reset
//            inc        - pulse: one point scored
//            game_over  - pulse: current game ended
//            clr        - pulse: new game starting
//            show_high  - level: 1 shows high score, 0 shows current score
//            num        - registered packed BCD display value
//            new_high   - last finished game set a new high score
//            saturated  - current score is all nines
//            state_over - FSM is in OVER
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    game_over,
  input  logic                    clr,
  input  logic                    show_high,
  output logic [NUM_DIGITS*4-1:0] num,
  output logic                    new_high,
  output logic                    saturated,
  output logic                    state_over
);

  localparam int W = NUM_DIGITS * 4;

  state_e         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   high_q, high_d;
  logic [W-1:0]   num_q, num_d;
  logic           new_high_q, new_high_d;

  logic [W-1:0]   w_score_inc;
  logic           w_all_nines;
  logic [W-1:0]   w_score_play;
  logic           w_gt;
  logic           w_decided;

  bcd_incrementer #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_inc (
    .value_i     (score_q),
    .sum_o       (w_score_inc),
    .all_nines_o (w_all_nines)
  );

  // Score as it stands after this cycle's inc, so a simultaneous game_over
  // compares against the incremented value.
  assign w_score_play = (inc && !w_all_nines) ? w_score_inc : score_q;

  // Most-significant digit first; the first unequal digit decides, and equal
  // scores fall through as not greater.
  always_comb begin
    w_gt      = 1'b0;
    w_decided = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!w_decided) begin
        if (w_score_play[i*4 +: 4] > high_q[i*4 +: 4]) begin
          w_gt      = 1'b1;
          w_decided = 1'b1;
        end else if (w_score_play[i*4 +: 4] < high_q[i*4 +: 4]) begin
          w_decided = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    num_d      = show_high ? high_q : score_q;

    case (state_q)
      PLAY: begin
        if (clr) begin
          // clr wins over both inc and game_over
          score_d = '0;
        end else begin
          score_d = w_score_play;
          if (game_over) begin
            state_d = OVER;
            if (w_gt) begin
              high_d     = w_score_play;
              new_high_d = 1'b1;
            end
          end
        end
      end
      OVER: begin
        if (clr) begin
          score_d    = '0;
          new_high_d = 1'b0;
          state_d    = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PLAY;
      score_q    <= '0;
      high_q     <= '0;
      num_q      <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      num_q      <= num_d;
      new_high_q <= new_high_d;
    end
  end

  assign num        = num_q;
  assign new_high   = new_high_q;
  assign saturated  = w_all_nines;
  assign state_over = (state_q == OVER);

endmodule : score_keeper
`default_nettype wire
